// File: rtl/exc_sequencer.sv
// exc_sequencer
// Arbitrates exception, interrupt and ERET requests from the IF/ID/EX stages
// of the 5-stage MIPS pipeline. Each accepted event becomes one COMMIT cycle
// (CP0 write strobes), a FLUSH phase of FLUSH_CYCLES unstalled cycles, and one
// REDIRECT cycle that loads the new fetch PC. Only one event runs at a time.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   stall_i                     pipeline stall; blocks acceptance, freezes FLUSH
//   int_pending_i, exl_i        unmasked interrupt pending, Status.EXL
//   {if,id,ex}_valid_i          stage holds a live instruction
//   {if,id,ex}_exc_i/_code_i    stage exception request and ExcCode
//   {if,id,ex}_pc_i/_badva_i    stage PC and faulting virtual address
//   {id,ex}_bd_i                stage instruction sits in a branch delay slot
//   eret_req_i, epc_in_i        ERET in EX, current CP0 EPC
//   busy_o, flush_o             sequencer active, kill IF/ID/EX
//   pc_redirect_o/redirect_pc_o fetch PC load strobe and target
//   cp0_*_o                     CP0 write strobes and data
module exc_sequencer #(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_i,
    input  logic        int_pending_i,
    input  logic        exl_i,
    input  logic        if_valid_i,
    input  logic        id_valid_i,
    input  logic        ex_valid_i,
    input  logic        if_exc_i,
    input  logic        id_exc_i,
    input  logic        ex_exc_i,
    input  logic [4:0]  if_code_i,
    input  logic [4:0]  id_code_i,
    input  logic [4:0]  ex_code_i,
    input  logic [31:0] if_pc_i,
    input  logic [31:0] id_pc_i,
    input  logic [31:0] ex_pc_i,
    input  logic        id_bd_i,
    input  logic        ex_bd_i,
    input  logic [31:0] if_badva_i,
    input  logic [31:0] id_badva_i,
    input  logic [31:0] ex_badva_i,
    input  logic        eret_req_i,
    input  logic [31:0] epc_in_i,
    output logic        busy_o,
    output logic        flush_o,
    output logic        pc_redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        cp0_we_o,
    output logic        cp0_epc_we_o,
    output logic [31:0] cp0_epc_o,
    output logic [4:0]  cp0_code_o,
    output logic        cp0_bd_o,
    output logic        cp0_badva_we_o,
    output logic [31:0] cp0_badva_o,
    output logic        cp0_exl_set_o,
    output logic        cp0_exl_clr_o
);

    typedef enum logic [1:0] {StIdle, StCommit, StFlush, StRedirect} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        eret_q;
    logic        flush_q;
    logic        pc_redirect_q;
    logic [31:0] redirect_pc_q;
    logic        cp0_we_q;
    logic        cp0_epc_we_q;
    logic [31:0] cp0_epc_q;
    logic [4:0]  cp0_code_q;
    logic        cp0_bd_q;
    logic        cp0_badva_we_q;
    logic [31:0] cp0_badva_q;
    logic        cp0_exl_set_q;
    logic        cp0_exl_clr_q;

    // Highest-ranked pending request this cycle.
    logic        sel_valid;
    logic        sel_eret;
    logic [4:0]  sel_code;
    logic [31:0] sel_pc;
    logic        sel_bd;
    logic [31:0] sel_badva;
    logic [31:0] sel_epc;
    logic        sel_badva_we;

    always_comb begin
        sel_valid = 1'b0;
        sel_eret  = 1'b0;
        sel_code  = 5'd0;
        sel_pc    = 32'd0;
        sel_bd    = 1'b0;
        sel_badva = 32'd0;
        if (int_pending_i && !exl_i && (ex_valid_i || id_valid_i)) begin
            // Interrupt attaches to the oldest live instruction.
            sel_valid = 1'b1;
            if (ex_valid_i) begin
                sel_pc    = ex_pc_i;
                sel_bd    = ex_bd_i;
                sel_badva = ex_badva_i;
            end else begin
                sel_pc    = id_pc_i;
                sel_bd    = id_bd_i;
                sel_badva = id_badva_i;
            end
        end else if (ex_valid_i && ex_exc_i) begin
            sel_valid = 1'b1;
            sel_code  = ex_code_i;
            sel_pc    = ex_pc_i;
            sel_bd    = ex_bd_i;
            sel_badva = ex_badva_i;
        end else if (ex_valid_i && eret_req_i) begin
            sel_valid = 1'b1;
            sel_eret  = 1'b1;
            sel_pc    = ex_pc_i;
            sel_bd    = ex_bd_i;
            sel_badva = ex_badva_i;
        end else if (id_valid_i && id_exc_i) begin
            sel_valid = 1'b1;
            sel_code  = id_code_i;
            sel_pc    = id_pc_i;
            sel_bd    = id_bd_i;
            sel_badva = id_badva_i;
        end else if (if_valid_i && if_exc_i) begin
            sel_valid = 1'b1;
            sel_code  = if_code_i;
            sel_pc    = if_pc_i;
            sel_badva = if_badva_i;
        end
    end

    assign sel_epc      = sel_bd ? (sel_pc - 32'd4) : sel_pc;
    // Address-error and TLB codes carry a faulting address.
    assign sel_badva_we = !sel_eret && (sel_code >= 5'd1) && (sel_code <= 5'd5);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= StIdle;
            cnt_q          <= 4'd0;
            eret_q         <= 1'b0;
            flush_q        <= 1'b0;
            pc_redirect_q  <= 1'b0;
            redirect_pc_q  <= 32'd0;
            cp0_we_q       <= 1'b0;
            cp0_epc_we_q   <= 1'b0;
            cp0_epc_q      <= 32'd0;
            cp0_code_q     <= 5'd0;
            cp0_bd_q       <= 1'b0;
            cp0_badva_we_q <= 1'b0;
            cp0_badva_q    <= 32'd0;
            cp0_exl_set_q  <= 1'b0;
            cp0_exl_clr_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            cp0_we_q       <= 1'b0;
            cp0_epc_we_q   <= 1'b0;
            cp0_badva_we_q <= 1'b0;
            cp0_exl_set_q  <= 1'b0;
            cp0_exl_clr_q  <= 1'b0;
            pc_redirect_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!stall_i && sel_valid) begin
                        state_q     <= StCommit;
                        flush_q     <= 1'b1;
                        eret_q      <= sel_eret;
                        cp0_code_q  <= sel_code;
                        cp0_bd_q    <= sel_bd;
                        cp0_epc_q   <= sel_epc;
                        cp0_badva_q <= sel_badva;
                        if (sel_eret) begin
                            cp0_exl_clr_q <= 1'b1;
                        end else begin
                            cp0_we_q       <= 1'b1;
                            cp0_epc_we_q   <= !exl_i;
                            cp0_badva_we_q <= sel_badva_we;
                            cp0_exl_set_q  <= 1'b1;
                        end
                    end
                end
                StCommit: begin
                    state_q       <= StFlush;
                    cnt_q         <= 4'(FLUSH_CYCLES);
                    redirect_pc_q <= eret_q ? epc_in_i : EXC_VECTOR;
                end
                StFlush: begin
                    if (!stall_i) begin
                        if (cnt_q == 4'd1) begin
                            state_q       <= StRedirect;
                            pc_redirect_q <= 1'b1;
                        end
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRedirect: begin
                    state_q <= StIdle;
                    flush_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    flush_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o         = (state_q != StIdle);
    assign flush_o        = flush_q;
    assign pc_redirect_o  = pc_redirect_q;
    assign redirect_pc_o  = redirect_pc_q;
    assign cp0_we_o       = cp0_we_q;
    assign cp0_epc_we_o   = cp0_epc_we_q;
    assign cp0_epc_o      = cp0_epc_q;
    assign cp0_code_o     = cp0_code_q;
    assign cp0_bd_o       = cp0_bd_q;
    assign cp0_badva_we_o = cp0_badva_we_q;
    assign cp0_badva_o    = cp0_badva_q;
    assign cp0_exl_set_o  = cp0_exl_set_q;
    assign cp0_exl_clr_o  = cp0_exl_clr_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: drives and samples 1 time unit after
// each rising clock edge.
module tb_exc_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall, int_pending, exl;
    logic        if_valid, id_valid, ex_valid;
    logic        if_exc, id_exc, ex_exc;
    logic [4:0]  if_code, id_code, ex_code;
    logic [31:0] if_pc, id_pc, ex_pc;
    logic        id_bd, ex_bd;
    logic [31:0] if_badva, id_badva, ex_badva;
    logic        eret_req;
    logic [31:0] epc_in;
    logic        busy, flush, pc_redirect;
    logic [31:0] redirect_pc;
    logic        cp0_we, cp0_epc_we;
    logic [31:0] cp0_epc;
    logic [4:0]  cp0_code;
    logic        cp0_bd, cp0_badva_we;
    logic [31:0] cp0_badva;
    logic        cp0_exl_set, cp0_exl_clr;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    exc_sequencer #(
        .EXC_VECTOR   (32'hBFC00380),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .stall_i        (stall),
        .int_pending_i  (int_pending),
        .exl_i          (exl),
        .if_valid_i     (if_valid),
        .id_valid_i     (id_valid),
        .ex_valid_i     (ex_valid),
        .if_exc_i       (if_exc),
        .id_exc_i       (id_exc),
        .ex_exc_i       (ex_exc),
        .if_code_i      (if_code),
        .id_code_i      (id_code),
        .ex_code_i      (ex_code),
        .if_pc_i        (if_pc),
        .id_pc_i        (id_pc),
        .ex_pc_i        (ex_pc),
        .id_bd_i        (id_bd),
        .ex_bd_i        (ex_bd),
        .if_badva_i     (if_badva),
        .id_badva_i     (id_badva),
        .ex_badva_i     (ex_badva),
        .eret_req_i     (eret_req),
        .epc_in_i       (epc_in),
        .busy_o         (busy),
        .flush_o        (flush),
        .pc_redirect_o  (pc_redirect),
        .redirect_pc_o  (redirect_pc),
        .cp0_we_o       (cp0_we),
        .cp0_epc_we_o   (cp0_epc_we),
        .cp0_epc_o      (cp0_epc),
        .cp0_code_o     (cp0_code),
        .cp0_bd_o       (cp0_bd),
        .cp0_badva_we_o (cp0_badva_we),
        .cp0_badva_o    (cp0_badva),
        .cp0_exl_set_o  (cp0_exl_set),
        .cp0_exl_clr_o  (cp0_exl_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        if_valid = 0; id_valid = 0; ex_valid = 0;
        if_exc = 0; id_exc = 0; ex_exc = 0;
        if_code = 0; id_code = 0; ex_code = 0;
        if_pc = 0; id_pc = 0; ex_pc = 0;
        id_bd = 0; ex_bd = 0;
        if_badva = 0; id_badva = 0; ex_badva = 0;
        eret_req = 0; int_pending = 0;
    endtask

    // Steps until pc_redirect is seen; n = steps taken, -1 on timeout.
    task automatic wait_redirect(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (pc_redirect) begin
                cnt = i;
                break;
            end
        end
    endtask

    initial begin
        resetn = 0; stall = 0; exl = 0; epc_in = 0;
        clear_req();
        step(); step();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_flush", {31'd0, flush}, 0);
        chk("rst_redir", {31'd0, pc_redirect}, 0);
        chk("rst_rpc", redirect_pc, 0);
        resetn = 1;
        step();

        // 1: EX exception, code 12
        ex_valid = 1; ex_exc = 1; ex_code = 12; ex_pc = 32'hBFC00100;
        step();
        clear_req();
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_flush", {31'd0, flush}, 1);
        chk("t1_we", {31'd0, cp0_we}, 1);
        chk("t1_epc_we", {31'd0, cp0_epc_we}, 1);
        chk("t1_epc", cp0_epc, 32'hBFC00100);
        chk("t1_code", {27'd0, cp0_code}, 12);
        chk("t1_badva_we", {31'd0, cp0_badva_we}, 0);
        chk("t1_exl_set", {31'd0, cp0_exl_set}, 1);
        chk("t1_exl_clr", {31'd0, cp0_exl_clr}, 0);
        step();
        chk("t1_we_pulse", {31'd0, cp0_we}, 0);
        chk("t1_flush2", {31'd0, flush}, 1);
        step();
        step();
        chk("t1_redir", {31'd0, pc_redirect}, 1);
        chk("t1_rpc", redirect_pc, 32'hBFC00380);
        step();
        chk("t1_idle", {31'd0, busy}, 0);
        chk("t1_idle_flush", {31'd0, flush}, 0);
        chk("t1_rpc_hold", redirect_pc, 32'hBFC00380);
        chk("t1_code_hold", {27'd0, cp0_code}, 12);

        // 2: ID exception in delay slot with bad address
        id_valid = 1; id_exc = 1; id_code = 4; id_pc = 32'h1000; id_bd = 1;
        id_badva = 32'h1003;
        step();
        clear_req();
        chk("t2_epc", cp0_epc, 32'h0FFC);
        chk("t2_bd", {31'd0, cp0_bd}, 1);
        chk("t2_badva_we", {31'd0, cp0_badva_we}, 1);
        chk("t2_badva", cp0_badva, 32'h1003);
        chk("t2_code", {27'd0, cp0_code}, 4);
        wait_redirect(n);
        chk("t2_lat", n, 3);
        step();

        // 3a: simultaneous requests plus interrupt, EXL clear
        if_valid = 1; if_exc = 1; if_code = 6; if_pc = 32'h2008;
        id_valid = 1; id_exc = 1; id_code = 10; id_pc = 32'h2004;
        ex_valid = 1; ex_exc = 1; ex_code = 5; ex_pc = 32'h2000; ex_badva = 32'h3000;
        int_pending = 1; exl = 0;
        step();
        chk("t3a_code", {27'd0, cp0_code}, 0);
        chk("t3a_epc", cp0_epc, 32'h2000);
        chk("t3a_epc_we", {31'd0, cp0_epc_we}, 1);
        chk("t3a_badva_we", {31'd0, cp0_badva_we}, 0);
        chk("t3a_we", {31'd0, cp0_we}, 1);
        // Requests held while busy must be ignored.
        wait_redirect(n);
        chk("t3a_lat", n, 3);
        clear_req();
        step();

        // 3b: same requests, EXL set masks the interrupt
        if_valid = 1; if_exc = 1; if_code = 6; if_pc = 32'h2008;
        id_valid = 1; id_exc = 1; id_code = 10; id_pc = 32'h2004;
        ex_valid = 1; ex_exc = 1; ex_code = 5; ex_pc = 32'h2000; ex_badva = 32'h3000;
        int_pending = 1; exl = 1;
        step();
        clear_req();
        exl = 0;
        chk("t3b_code", {27'd0, cp0_code}, 5);
        chk("t3b_epc_we", {31'd0, cp0_epc_we}, 0);
        chk("t3b_epc", cp0_epc, 32'h2000);
        chk("t3b_badva_we", {31'd0, cp0_badva_we}, 1);
        chk("t3b_badva", cp0_badva, 32'h3000);
        wait_redirect(n);
        chk("t3b_lat", n, 3);
        step();

        // 4a: ERET
        ex_valid = 1; eret_req = 1; ex_pc = 32'h4000; epc_in = 32'h80001234;
        step();
        clear_req();
        chk("t4a_clr", {31'd0, cp0_exl_clr}, 1);
        chk("t4a_we", {31'd0, cp0_we}, 0);
        chk("t4a_set", {31'd0, cp0_exl_set}, 0);
        chk("t4a_epc_we", {31'd0, cp0_epc_we}, 0);
        chk("t4a_badva_we", {31'd0, cp0_badva_we}, 0);
        wait_redirect(n);
        chk("t4a_lat", n, 3);
        chk("t4a_rpc", redirect_pc, 32'h80001234);
        step();

        // 4b: ERET with EX exception; exception wins
        ex_valid = 1; eret_req = 1; ex_exc = 1; ex_code = 8; ex_pc = 32'h4100;
        step();
        clear_req();
        chk("t4b_we", {31'd0, cp0_we}, 1);
        chk("t4b_clr", {31'd0, cp0_exl_clr}, 0);
        chk("t4b_code", {27'd0, cp0_code}, 8);
        wait_redirect(n);
        chk("t4b_rpc", redirect_pc, 32'hBFC00380);
        step();

        // 5a: stall blocks acceptance
        ex_valid = 1; ex_exc = 1; ex_code = 12; ex_pc = 32'h5000; stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5a_stalled", {31'd0, busy}, 0);
        end
        stall = 0;
        step();
        clear_req();
        chk("t5a_accept", {31'd0, cp0_we}, 1);
        chk("t5a_epc", cp0_epc, 32'h5000);
        // 5b: stall during FLUSH delays REDIRECT by 2
        step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t5b_flush", {31'd0, flush}, 1);
            chk("t5b_no_redir", {31'd0, pc_redirect}, 0);
        end
        stall = 0;
        wait_redirect(n);
        chk("t5b_lat", n, 2);
        step();

        // 6: reset during FLUSH
        id_valid = 1; id_exc = 1; id_code = 4; id_pc = 32'h6000; id_badva = 32'h6001;
        step();
        clear_req();
        step();
        resetn = 0;
        step();
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_flush", {31'd0, flush}, 0);
        chk("t6_rpc", redirect_pc, 0);
        chk("t6_epc", cp0_epc, 0);
        chk("t6_code", {27'd0, cp0_code}, 0);
        chk("t6_badva", cp0_badva, 0);
        chk("t6_we", {31'd0, cp0_we}, 0);
        resetn = 1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (pc_redirect || busy) n++;
        end
        chk("t6_quiet", n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
Arbitrates exception, interrupt and ERET requests from the fetch, decode and execute stages of the 5-stage MIPS pipeline, and sequences each one into CP0 updates, a pipeline flush and a PC redirect. It sits between the stage exception-detect logic and the CP0 register file. It turns concurrent, unordered requests into one precise, oldest-first event at a time.

Parameters:
EXC_VECTOR, 32'hBFC00380, general exception handler entry address
FLUSH_CYCLES, 2, number of FLUSH-state cycles (legal range 1..15)

Ports:
clk  in  1  clock
resetn  in  1  synchronous active-low reset
stall  in  1  pipeline stall (SRAM wait); no new event is accepted while high
int_pending  in  1  unmasked interrupt pending, from CP0 (Cause.IP & Status.IM & IE)
exl  in  1  Status.EXL from CP0
if_valid, id_valid, ex_valid  in  1 each  the stage holds a live instruction
if_exc, id_exc, ex_exc  in  1 each  the stage reports an exception
if_code, id_code, ex_code  in  5 each  ExcCode for that stage
if_pc, id_pc, ex_pc  in  32 each  PC of the stage instruction
id_bd, ex_bd  in  1 each  the stage instruction is in a branch delay slot
if_badva, id_badva, ex_badva  in  32 each  faulting virtual address
eret_req  in  1  ERET in the EX stage
epc_in  in  32  current CP0 EPC
busy  out  1  sequencer not idle
flush  out  1  kill all IF/ID/EX contents
pc_redirect  out  1  one-cycle strobe that loads redirect_pc into the fetch PC
redirect_pc  out  32  redirect target
cp0_we  out  1  one-cycle strobe that writes Cause.ExcCode and Cause.BD
cp0_epc_we  out  1  one-cycle strobe that writes EPC
cp0_epc  out  32  EPC value to write
cp0_code  out  5  ExcCode value
cp0_bd  out  1  Cause.BD value
cp0_badva_we  out  1  one-cycle strobe that writes BadVAddr
cp0_badva  out  32  BadVAddr value
cp0_exl_set, cp0_exl_clr  out  1 each  one-cycle strobes that set or clear Status.EXL

Behaviour:
- Reset: resetn low at a clk edge forces state IDLE and clears the flush counter. It also drives every output to 0, including redirect_pc and the data buses. Reset mid-sequence aborts the sequence with no further strobes.
- States: IDLE, COMMIT, FLUSH, REDIRECT. busy = (state != IDLE).
- IDLE accepts an event only when stall=0. Events are ranked highest first:
  1. Interrupt: int_pending & ~exl & (ex_valid | id_valid). It attaches to the EX instruction if ex_valid, otherwise to the ID instruction. Code = 0.
  2. ex_valid & ex_exc.
  3. ex_valid & eret_req.
  4. id_valid & id_exc.
  5. if_valid & if_exc.
- On acceptance, latch the following, then go to COMMIT:
  - kind (exception or eret), code, pc, bd and badva of the chosen stage;
  - bd for IF is 0.
- Selected-event rules:
  - EPC value = bd ? pc-4 : pc (32-bit wrap).
  - badva_we is set when code ∈ {1,2,3,4,5}.
  - epc_we is set when exl=0 at acceptance.
- COMMIT lasts 1 cycle.
  - Exception: cp0_we=1, cp0_epc_we=latched epc_we, cp0_badva_we=latched badva_we, cp0_exl_set=1.
  - ERET: cp0_exl_clr=1 only, and redirect_pc is latched from epc_in.
- COMMIT → FLUSH with counter=FLUSH_CYCLES.
- FLUSH:
  - The counter decrements on each cycle with stall=0 and holds while stall=1.
  - When counter==1 and stall=0, go to REDIRECT.
- REDIRECT lasts 1 cycle with pc_redirect=1, then returns to IDLE.
  - redirect_pc = EXC_VECTOR for an exception, or the latched EPC for ERET.
  - redirect_pc holds its value until the next acceptance.
- flush=1 in COMMIT, FLUSH and REDIRECT; 0 in IDLE.
- Latency: an event sampled in IDLE at edge T gives COMMIT in cycle T+1 and REDIRECT in cycle T+2+FLUSH_CYCLES (no stalls).
- All request inputs are ignored while busy. Stage logic holds an unserviced request until it is flushed.
- Simultaneous requests: exactly one is serviced; lower-ranked ones are discarded by the flush.
- cp0_code, cp0_bd, cp0_epc and cp0_badva stay stable from COMMIT until the next acceptance.

Test Plan:
1. ex_exc=1, code=12, ex_pc=0xBFC00100, ex_bd=0, exl=0 → COMMIT: cp0_we=1, cp0_epc_we=1, cp0_epc=0xBFC00100, cp0_code=12, cp0_badva_we=0, exl_set=1; pc_redirect to 0xBFC00380 four cycles after acceptance.
2. id_exc code=4, id_pc=0x1000, id_bd=1, id_badva=0x1003 → cp0_epc=0x0FFC, cp0_bd=1, cp0_badva_we=1, cp0_badva=0x1003.
3. Simultaneous if_exc, id_exc and ex_exc (code 5), plus int_pending=1, exl=0, ex_pc=0x2000 → only the interrupt is serviced: code=0, cp0_epc=0x2000. Same requests with exl=1 → the EX exception is serviced with code=5 and cp0_epc_we=0.
4. eret_req=1, epc_in=0x80001234, no exception → exl_clr=1, cp0_we=0, pc_redirect to 0x80001234. eret_req together with ex_exc → the exception wins.
5. Request presented with stall=1 for 3 cycles → no acceptance until stall falls. stall=1 for 2 cycles during FLUSH → REDIRECT is delayed by exactly 2 cycles and flush stays high throughout.
6. resetn=0 during FLUSH → next cycle state IDLE and all outputs 0; no pc_redirect follows after reset is released.
